// File: rtl/alu_decision_sequencer_if.sv
// Row-request and action handshake bundle for alu_decision_sequencer.
//   in_valid / in_ready / img_row / velocity_en : one image row per request
//   out_valid / out_ready / action              : one action per row
// The master modport belongs to the row source / action consumer. The slave
// modport belongs to the sequencer.
interface alu_decision_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] img_row;
    logic        velocity_en;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  action;

    modport master (
        output in_valid, img_row, velocity_en, out_ready,
        input  in_ready, out_valid, action
    );

    modport slave (
        input  in_valid, img_row, velocity_en, out_ready,
        output in_ready, out_valid, action
    );
endinterface

// File: rtl/alu_decision_sequencer.sv
// alu_decision_sequencer: per-row obstacle-avoidance sequencer driving custom_alu.
// For each accepted row it issues the ALU chain
//   VELOCITY_GUARD -> OB_CHECK -> MOVE_LEFT/MOVE_RIGHT/STOP -> SUB/ADD
// and it tracks the car column. It emits one action per row over a valid/ready handshake.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   bus (slave)           row request in, action out (alu_decision_sequencer_if)
//   alu_opcode/a/b        registered ALU operands; this block is their only driver
//   alu_result/alu_valid  ALU response, sampled in the last wait cycle of each op
//   car_x                 current car column
//   err                   one-cycle pulse when an ALU op was sampled with alu_valid=0
//   stop_cnt/steer_cnt    row statistics (live only with ALU_SEQ_STATS_EN)
// Optional feature macro: ALU_SEQ_STATS_EN enables the saturating statistics counters.
module alu_decision_sequencer #(
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned CAR_X_INIT = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    alu_decision_sequencer_if.slave         bus,
    output logic [4:0]                      alu_opcode,
    output logic [15:0]                     alu_a,
    output logic [15:0]                     alu_b,
    input  logic [15:0]                     alu_result,
    input  logic                            alu_valid,
    output logic [3:0]                      car_x,
    output logic                            err,
    output logic [15:0]                     stop_cnt,
    output logic [15:0]                     steer_cnt
);

    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_NOP   = 5'b01001;
    localparam logic [4:0] OP_OB    = 5'b01010;
    localparam logic [4:0] OP_LEFT  = 5'b01011;
    localparam logic [4:0] OP_RIGHT = 5'b01100;
    localparam logic [4:0] OP_STOP  = 5'b01101;
    localparam logic [4:0] OP_VG    = 5'b01111;

    localparam logic [1:0] ACT_STOP  = 2'd0;
    localparam logic [1:0] ACT_LEFT  = 2'd1;
    localparam logic [1:0] ACT_RIGHT = 2'd2;
    localparam logic [1:0] ACT_CONT  = 2'd3;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_VG_ISSUE  = 4'd1;
    localparam logic [3:0] S_VG_WAIT   = 4'd2;
    localparam logic [3:0] S_OB_ISSUE  = 4'd3;
    localparam logic [3:0] S_OB_WAIT   = 4'd4;
    localparam logic [3:0] S_ST_ISSUE  = 4'd5;
    localparam logic [3:0] S_ST_WAIT   = 4'd6;
    localparam logic [3:0] S_POS_ISSUE = 4'd7;
    localparam logic [3:0] S_POS_WAIT  = 4'd8;
    localparam logic [3:0] S_EMIT      = 4'd9;

    localparam logic [2:0] LAST_WAIT = 3'(ALU_LAT - 1);

    logic [3:0]  state_q,     state_d;
    logic [2:0]  wait_q,      wait_d;
    logic [15:0] row_q,       row_d;
    logic        vel_q,       vel_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  action_q,    action_d;
    logic [4:0]  opcode_q,    opcode_d;
    logic [15:0] a_q,         a_d;
    logic [15:0] b_q,         b_d;
    logic [3:0]  car_q,       car_d;
    logic        err_q,       err_d;

    logic        lat_done_c;
    logic        left_free_c;
    logic        right_free_c;
    logic        go_emit;
    logic [1:0]  emit_act;

    // The result is usable in the last of the ALU_LAT wait cycles.
    assign lat_done_c   = (wait_q == LAST_WAIT);
    // Steering preference is decided locally. LEFT wins when both sides are free.
    assign left_free_c  = (car_q != 4'd0)  && !row_q[car_q - 4'd1];
    assign right_free_c = (car_q != 4'd15) && !row_q[car_q + 4'd1];

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        row_d       = row_q;
        vel_d       = vel_q;
        out_valid_d = out_valid_q;
        action_d    = action_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        car_d       = car_q;
        err_d       = 1'b0;
        go_emit     = 1'b0;
        emit_act    = ACT_STOP;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    row_d   = bus.img_row;
                    vel_d   = bus.velocity_en;
                    state_d = S_VG_ISSUE;
                end
            end
            S_VG_ISSUE: begin
                opcode_d = OP_VG;
                a_d      = {15'b0, vel_q};
                b_d      = 16'd0;
                wait_d   = 3'd0;
                state_d  = S_VG_WAIT;
            end
            S_VG_WAIT: begin
                if (!lat_done_c) begin
                    wait_d = wait_q + 3'd1;
                end else if (!alu_valid) begin
                    err_d   = 1'b1;
                    go_emit = 1'b1;
                end else if (alu_result == 16'd3) begin
                    state_d = S_OB_ISSUE;
                end else begin
                    go_emit = 1'b1;
                end
            end
            S_OB_ISSUE: begin
                opcode_d = OP_OB;
                a_d      = row_q;
                b_d      = {12'b0, car_q};
                wait_d   = 3'd0;
                state_d  = S_OB_WAIT;
            end
            S_OB_WAIT: begin
                if (!lat_done_c) begin
                    wait_d = wait_q + 3'd1;
                end else if (!alu_valid) begin
                    err_d   = 1'b1;
                    go_emit = 1'b1;
                end else if (alu_result == 16'd3) begin
                    go_emit  = 1'b1;
                    emit_act = ACT_CONT;
                end else begin
                    state_d = S_ST_ISSUE;
                end
            end
            S_ST_ISSUE: begin
                if (left_free_c) begin
                    opcode_d = OP_LEFT;
                end else if (right_free_c) begin
                    opcode_d = OP_RIGHT;
                end else begin
                    opcode_d = OP_STOP;
                end
                a_d     = row_q;
                b_d     = {12'b0, car_q};
                wait_d  = 3'd0;
                state_d = S_ST_WAIT;
            end
            S_ST_WAIT: begin
                if (!lat_done_c) begin
                    wait_d = wait_q + 3'd1;
                end else if (!alu_valid) begin
                    err_d   = 1'b1;
                    go_emit = 1'b1;
                end else if (alu_result[1:0] == ACT_LEFT || alu_result[1:0] == ACT_RIGHT) begin
                    action_d = alu_result[1:0];
                    state_d  = S_POS_ISSUE;
                end else begin
                    go_emit = 1'b1;
                end
            end
            S_POS_ISSUE: begin
                opcode_d = (action_q == ACT_LEFT) ? OP_SUB : OP_ADD;
                a_d      = {12'b0, car_q};
                b_d      = 16'd1;
                wait_d   = 3'd0;
                state_d  = S_POS_WAIT;
            end
            S_POS_WAIT: begin
                if (!lat_done_c) begin
                    wait_d = wait_q + 3'd1;
                end else if (!alu_valid) begin
                    err_d   = 1'b1;
                    go_emit = 1'b1;
                end else begin
                    // STEER only picks a side that exists, so this never wraps.
                    car_d    = alu_result[3:0];
                    go_emit  = 1'b1;
                    emit_act = action_q;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common entry into EMIT. The ALU is parked on NOP while the action waits.
        if (go_emit) begin
            state_d     = S_EMIT;
            out_valid_d = 1'b1;
            action_d    = emit_act;
            opcode_d    = OP_NOP;
            a_d         = 16'd0;
            b_d         = 16'd0;
        end

        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= 3'd0;
            row_q       <= 16'd0;
            vel_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            action_q    <= ACT_STOP;
            opcode_q    <= OP_NOP;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            car_q       <= 4'(CAR_X_INIT);
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            row_q       <= row_d;
            vel_q       <= vel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            action_q    <= action_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            car_q       <= car_d;
            err_q       <= err_d;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stop_cnt_q;
    logic [15:0] steer_cnt_q;

    // Count each accepted action. Both counters saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_cnt_q  <= 16'd0;
            steer_cnt_q <= 16'd0;
        end else if (out_valid_q && bus.out_ready) begin
            if (action_q == ACT_STOP && stop_cnt_q != 16'hFFFF) begin
                stop_cnt_q <= stop_cnt_q + 16'd1;
            end
            if ((action_q == ACT_LEFT || action_q == ACT_RIGHT) && steer_cnt_q != 16'hFFFF) begin
                steer_cnt_q <= steer_cnt_q + 16'd1;
            end
        end
    end

    assign stop_cnt  = stop_cnt_q;
    assign steer_cnt = steer_cnt_q;
`else
    assign stop_cnt  = 16'd0;
    assign steer_cnt = 16'd0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.action    = action_q;
    assign alu_opcode    = opcode_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign car_x         = car_q;
    assign err           = err_q;

endmodule
